decrypted_message_checker: RTL
==============================

Name: decrypted_message_checker

Overview:
Reader side of the decrypted-message RAM. After the RC4 decrypt stage has filled the RAM and the top-level controller asserts start, this block reads the bytes in address order. It checks that every byte is a lowercase letter (8'h61–8'h7A) or a space (8'h20). It reports valid_flag or invalid_flag to the controller, which uses the result to accept the current secret key or advance to the next one. It owns the RAM read port while busy and never writes.

Parameters:
MSG_LEN, 32, number of message bytes checked (addresses 0..MSG_LEN-1); must be ≤ 2**ADDR_W
ADDR_W, 5, RAM address width
READ_LATENCY, 1, clock cycles between an address update and the cycle in which Decrypted_Message_q is valid to sample (≥1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  level/pulse from controller; accepted only in IDLE or DONE
Decrypted_Message_address  output  ADDR_W  RAM read address
Decrypted_Message_wren  output  1  RAM write enable, constant 0
Decrypted_Message_q  input  8  RAM read data
busy  output  1  high from the start-accept edge until done rises
done  output  1  high in DONE state (sticky)
valid_flag  output  1  all MSG_LEN bytes passed; sticky with done
invalid_flag  output  1  a byte failed; sticky with done
fail_addr  output  ADDR_W  address of the first failing byte; 0 if none
fail_char  output  8  value of the first failing byte; 0 if none

Behaviour:
- Reset (async, any state): state=IDLE; address=0; busy, done, valid_flag, invalid_flag=0; fail_addr=0; fail_char=0; wait counter=0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE: when start=1 at an edge, set address<=0, wait_cnt<=0, busy<=1, and go to WAIT.
- DONE with start=1: identical to IDLE accept. In the same edge, clear done, valid_flag, invalid_flag, fail_addr and fail_char. This supports re-checking for the next key without a reset.
- WAIT: wait_cnt increments each cycle. When wait_cnt==READ_LATENCY-1, go to CHECK. The WAIT dwell is exactly READ_LATENCY cycles.
- CHECK: sample Decrypted_Message_q once.
  - pass and address==MSG_LEN-1: valid_flag<=1, done<=1, busy<=0, go to DONE.
  - pass otherwise: address<=address+1, wait_cnt<=0, go to WAIT.
  - fail: invalid_flag<=1, done<=1, busy<=0, fail_addr<=address, fail_char<=q, go to DONE. The remaining bytes are not read (early exit).
- Pass test: q==8'h20, or 8'h61≤q≤8'h7A (unsigned compare). Boundary values 8'h60, 8'h7B, 8'h00 and 8'hFF fail.
- Address never exceeds MSG_LEN-1 and never wraps. It holds its last value in DONE.
- Timing, cycles per byte = READ_LATENCY+1. Byte k is sampled (READ_LATENCY+1)(k+1) edges after the start-accept edge. With defaults, done and valid_flag are visible after edge 64.
- start while busy (WAIT/CHECK) is ignored.
- valid_flag and invalid_flag are mutually exclusive. Neither is ever high while busy=1.
- Decrypted_Message_wren is tied 0 in every state, including reset.

Test Plan:
- All valid: preload RAM with 32 bytes of "a".."z" and spaces, pulse start → busy for 64 cycles, address sweeps 0..31, then done=1, valid_flag=1, invalid_flag=0, fail_addr=0.
- Early fail: RAM[5]=8'h41 ('A'), rest valid, start → done after 12 cycles, invalid_flag=1, fail_addr=5, fail_char=8'h41; address holds at 5 and is never driven to 6.
- Boundaries: check the single byte at address 0 with each of 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h1F → fail, pass, pass, fail, pass, fail respectively.
- Restart from DONE: after an invalid result, fix the RAM and pulse start → flags clear on the accept edge, then valid_flag=1 after 64 cycles; a start pulse during busy has no effect on timing.
- Async reset mid-check: assert reset at byte 10 without waiting for a clock edge → all outputs are 0 immediately and state is IDLE; after release, a new start gives a full 64-cycle pass.
- READ_LATENCY=2 build: RAM model with 2-cycle latency, all-valid message → done after 96 cycles, valid_flag=1; Decrypted_Message_wren stays 0 throughout.

Source files
------------

// File: rtl/decrypted_message_checker_if.sv
// Read port of the decrypted-message RAM plus the start/result handshake with the key controller.
// The checker uses the slave modport; the controller and RAM side use master.
interface decrypted_message_checker_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] Decrypted_Message_address;
  logic              Decrypted_Message_wren;
  logic [7:0]        Decrypted_Message_q;
  logic              busy;
  logic              done;
  logic              valid_flag;
  logic              invalid_flag;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0]        fail_char;

  modport slave (
    input  start, Decrypted_Message_q,
    output Decrypted_Message_address, Decrypted_Message_wren,
    output busy, done, valid_flag, invalid_flag, fail_addr, fail_char
  );

  modport master (
    output start, Decrypted_Message_q,
    input  Decrypted_Message_address, Decrypted_Message_wren,
    input  busy, done, valid_flag, invalid_flag, fail_addr, fail_char
  );
endinterface

// File: rtl/decrypted_message_checker.sv
// Walks the decrypted-message RAM in address order and flags any byte that is not 'a'..'z' or space.
// Each byte costs READ_LATENCY+1 cycles; start is ignored while busy and exits early on the first bad byte.
module decrypted_message_checker #(
  parameter int MSG_LEN      = 32,
  parameter int ADDR_W       = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  decrypted_message_checker_if.slave    bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] address, address_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              valid_flag, valid_flag_nxt;
  logic              invalid_flag, invalid_flag_nxt;
  logic [ADDR_W-1:0] fail_addr, fail_addr_nxt;
  logic [7:0]        fail_char, fail_char_nxt;
  logic              char_ok;

  assign char_ok = (bus.Decrypted_Message_q == 8'h20) ||
                   ((bus.Decrypted_Message_q >= 8'h61) && (bus.Decrypted_Message_q <= 8'h7A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      address      <= '0;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid_flag   <= 1'b0;
      invalid_flag <= 1'b0;
      fail_addr    <= '0;
      fail_char    <= '0;
    end else begin
      state        <= state_nxt;
      address      <= address_nxt;
      wait_cnt     <= wait_cnt_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      valid_flag   <= valid_flag_nxt;
      invalid_flag <= invalid_flag_nxt;
      fail_addr    <= fail_addr_nxt;
      fail_char    <= fail_char_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    address_nxt      = address;
    wait_cnt_nxt     = wait_cnt;
    busy_nxt         = busy;
    done_nxt         = done;
    valid_flag_nxt   = valid_flag;
    invalid_flag_nxt = invalid_flag;
    fail_addr_nxt    = fail_addr;
    fail_char_nxt    = fail_char;

    case (state)
      // A restart from DONE also wipes the previous key's verdict.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt        = S_WAIT;
          address_nxt      = '0;
          wait_cnt_nxt     = '0;
          busy_nxt         = 1'b1;
          done_nxt         = 1'b0;
          valid_flag_nxt   = 1'b0;
          invalid_flag_nxt = 1'b0;
          fail_addr_nxt    = '0;
          fail_char_nxt    = '0;
        end
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt + 1'b1;
        if (wait_cnt == LAST_WAIT) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!char_ok) begin
          state_nxt        = S_DONE;
          invalid_flag_nxt = 1'b1;
          done_nxt         = 1'b1;
          busy_nxt         = 1'b0;
          fail_addr_nxt    = address;
          fail_char_nxt    = bus.Decrypted_Message_q;
        end else if (address == LAST_ADDR) begin
          state_nxt      = S_DONE;
          valid_flag_nxt = 1'b1;
          done_nxt       = 1'b1;
          busy_nxt       = 1'b0;
        end else begin
          state_nxt    = S_WAIT;
          address_nxt  = address + 1'b1;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.Decrypted_Message_address = address;
  assign bus.Decrypted_Message_wren    = 1'b0;
  assign bus.busy                      = busy;
  assign bus.done                      = done;
  assign bus.valid_flag                = valid_flag;
  assign bus.invalid_flag              = invalid_flag;
  assign bus.fail_addr                 = fail_addr;
  assign bus.fail_char                 = fail_char;

endmodule
